univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the single-bit D flip-flop in the lab storage library. It generalises the one-bit `d`/`q` register to a `WIDTH`-bit register with enable, parallel load, shift-left, shift-right and hold modes. It also keeps a saturating count of shifts since the last load. It serves as the storage and serialisation primitive for the serial-transfer and arithmetic exercises that follow.

---
 rtl/univ_shift_reg.sv | 109 ++++++++++
 tb/tb_univ_shift_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - WIDTH-bit universal shift register with saturating shift count (optional USR_ROTATE_EN)
//
// Modes: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
// Define USR_ROTATE_EN to turn both shifts into rotates; the sin_l/sin_r
// ports stay present but are ignored in that build.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [1:0]                     mode,
  input  logic [WIDTH-1:0]               d,
  input  logic                           sin_l,
  input  logic                           sin_r,
  output logic [WIDTH-1:0]               q,
  output logic                           sout_r,
  output logic                           sout_l,
  output logic [$clog2(WIDTH+1)-1:0]     cnt,
  output logic                           full
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Reject widths outside the supported range at elaboration time.
  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("univ_shift_reg: WIDTH must be in 2..32");
  end

  logic             fill_l;   // bit entering at the MSB on a right shift
  logic             fill_r;   // bit entering at the LSB on a left shift
  logic [CNT_W-1:0] cnt_inc;  // saturating increment of the shift count
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_next;
  logic             full_next;

`ifdef USR_ROTATE_EN
  // Rotating build: the bit leaving one end re-enters at the other.
  logic unused_sin;
  assign unused_sin = sin_l ^ sin_r;
  assign fill_l     = q[0];
  assign fill_r     = q[WIDTH-1];
`else
  assign fill_l = sin_l;
  assign fill_r = sin_r;
`endif

  // Serial outputs expose the bit that would leave on the next shift.
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  // Count stops at WIDTH; once every loaded bit has left, it never wraps.
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  // Next-state selection by mode; hold keeps everything as is.
  always_comb begin
    q_next    = q;
    cnt_next  = cnt;
    full_next = full;
    case (mode)
      MODE_HOLD: begin
        q_next    = q;
        cnt_next  = cnt;
        full_next = full;
      end
      MODE_RIGHT: begin
        q_next    = {fill_l, q[WIDTH-1:1]};
        cnt_next  = cnt_inc;
        full_next = (cnt_inc == CNT_MAX);
      end
      MODE_LEFT: begin
        q_next    = {q[WIDTH-2:0], fill_r};
        cnt_next  = cnt_inc;
        full_next = (cnt_inc == CNT_MAX);
      end
      MODE_LOAD: begin
        q_next    = d;
        cnt_next  = '0;
        full_next = 1'b0;
      end
      default: begin
        q_next    = q;
        cnt_next  = cnt;
        full_next = full;
      end
    endcase
  end

  // State register: reset wins over enable, enable gates every update.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      full <= 1'b0;
    end else if (en) begin
      q    <= q_next;
      cnt  <= cnt_next;
      full <= full_next;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0)
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] q;
  logic         sout_r;
  logic         sout_l;
  logic [3:0]   cnt;
  logic         full;

  int checks = 0;
  int errors = 0;

  // Reference state: register value and number of shifts since load/reset.
  int m_q   = 0;
  int m_cnt = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .full   (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},      {24'd0, q},      32'(m_q));
    check({tag, ".cnt"},    {28'd0, cnt},    32'(m_cnt));
    check({tag, ".full"},   {31'd0, full},   32'(m_cnt == W));
    check({tag, ".sout_r"}, {31'd0, sout_r}, 32'(m_q % 2));
    check({tag, ".sout_l"}, {31'd0, sout_l}, 32'(m_q / 128));
  endtask

  // Drive one cycle of inputs, advance the model by the register's rules,
  // then compare 1 time unit after the rising edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] dd, input logic sl, input logic sr);
    int bit_in;
    reset = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    @(posedge clk);
    if (r) begin
      m_q = 0; m_cnt = 0;
    end else if (e) begin
      if (m == 2'b01) begin
`ifdef USR_ROTATE_EN
        bit_in = m_q % 2;
`else
        bit_in = int'(sl);
`endif
        m_q   = (m_q / 2) + bit_in * 128;
        m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
      end else if (m == 2'b10) begin
`ifdef USR_ROTATE_EN
        bit_in = m_q / 128;
`else
        bit_in = int'(sr);
`endif
        m_q   = ((m_q * 2) % 256) + bit_in;
        m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
      end else if (m == 2'b11) begin
        m_q = int'(dd); m_cnt = 0;
      end
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; d = '0; sin_l = 1'b0; sin_r = 1'b0;

    // Reset and load
    step("reset", 1'b1, 1'b0, 2'b01, 8'hFF, 1'b1, 1'b1);
    check("reset_q", {24'd0, q}, 32'h00);
    check("reset_cnt", {28'd0, cnt}, 32'd0);
    check("reset_full", {31'd0, full}, 32'd0);
    step("load_a5", 1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    check("load_q", {24'd0, q}, 32'hA5);
    check("load_sout_l", {31'd0, sout_l}, 32'd1);
    check("load_sout_r", {31'd0, sout_r}, 32'd1);

    // Single shifts from 0xA5
    step("shr", 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
`ifdef USR_ROTATE_EN
    check("shr_q", {24'd0, q}, 32'hD2);
`else
    check("shr_q", {24'd0, q}, 32'h52);
`endif
    check("shr_cnt", {28'd0, cnt}, 32'd1);
    step("reload_a5", 1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    step("shl", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
    check("shl_q", {24'd0, q}, 32'h4B);
    check("shl_cnt", {28'd0, cnt}, 32'd1);

    // Saturation
    step("load_ff", 1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("sat_shift", 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
`ifdef USR_ROTATE_EN
    check("sat8_q", {24'd0, q}, 32'hFF);
`else
    check("sat8_q", {24'd0, q}, 32'h00);
`endif
    check("sat8_cnt", {28'd0, cnt}, 32'd8);
    check("sat8_full", {31'd0, full}, 32'd1);
    step("sat9", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
    check("sat9_cnt", {28'd0, cnt}, 32'd8);
    check("sat9_full", {31'd0, full}, 32'd1);

    // Enable gating
    step("load_3c", 1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
    step("shift_3c", 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("en_low", 1'b0, 1'b0, 2'b11, 8'hFF, 1'b1, 1'b1);
    check("en_low_q", {24'd0, q}, 32'h3C);
    check("en_low_cnt", {28'd0, cnt}, 32'd0);

    // Reset priority over en=0 and a shift request
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
    check("pre_rst_cnt", {28'd0, cnt}, 32'd4);
    step("rst_prio", 1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1);
    check("rst_prio_q", {24'd0, q}, 32'h00);
    check("rst_prio_cnt", {28'd0, cnt}, 32'd0);
    check("rst_prio_full", {31'd0, full}, 32'd0);

`ifdef USR_ROTATE_EN
    // Rotation wraps the outgoing bit back in
    step("load_81", 1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    step("rotr", 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    check("rotr_q", {24'd0, q}, 32'hC0);
    step("load_81b", 1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    step("rotl", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
    check("rotl_q", {24'd0, q}, 32'h03);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)),
           8'($urandom),
           1'($urandom),
           1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
